wb_byte_en_sram_ctrl: RTL and testbench

- Wishbone (classic, single-transfer) slave that bridges bus cycles onto an internal synchronous single-port SRAM with per-byte write enables.
- Sits on a system Wishbone interconnect as a scratch/program memory; the bridge FSM and the memory array are contained in this block.
- One clock domain.

---
 rtl/wb_sram_pkg.sv | 16 +
 rtl/byte_en_sram_mem.sv | 35 +++
 rtl/wb_byte_en_sram_ctrl.sv | 110 +++++++++++
 tb/tb_wb_byte_en_sram_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone byte-enable SRAM bridge.
package wb_sram_pkg;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

    // Number of byte-offset address bits for a given bus data width.
    function automatic int ofs_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/byte_en_sram_mem.sv
// Synchronous single-port SRAM with per-byte write enables and a registered
// read port (1-cycle latency). The array is never reset.
// Each byte lane is an independent 8-bit wide array built in a generate loop.
module byte_en_sram_mem
    import wb_sram_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int NB        = 4
) (
    input  logic                     clk,
    input  logic [ADDR_BITS-1:0]     addr,
    input  logic                     we,
    input  logic [NB-1:0]            byte_en,
    input  logic [NB-1:0][7:0]       wdata,
    output logic [NB-1:0][7:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_q;

        // Byte-lane write and registered read; a read during a write returns old data.
        always_ff @(posedge clk) begin
            if (we && byte_en[i]) begin
                lane_mem[addr] <= wdata[i];
            end
            rd_q <= lane_mem[addr];
        end

        assign rdata[i] = rd_q;
    end

endmodule

// File: rtl/wb_byte_en_sram_ctrl.sv
// Wishbone classic single-transfer slave in front of a byte-enable SRAM.
// Writes ack one cycle after acceptance, reads two cycles after; a mandatory
// ACK state between transfers stops a held strobe from being double-acked.
// Optional: define WB_SRAM_ADDR_CHECK_EN to answer out-of-range addresses
// with err instead of aliasing onto the array.
module wb_byte_en_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int MEM_ADDR_BITS    = 10,
    parameter int WB_ADDRESS_WIDTH = 32,
    parameter int WB_DATA_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [WB_ADDRESS_WIDTH-1:0]  adr,
    input  logic [WB_DATA_WIDTH-1:0]     dat_w,
    output logic [WB_DATA_WIDTH-1:0]     dat_r,
    input  logic                         cyc,
    input  logic                         stb,
    input  logic                         we,
    input  logic [WB_DATA_WIDTH/8-1:0]   sel,
    output logic                         ack,
    output logic                         err
);

    localparam int NB  = WB_DATA_WIDTH / 8;
    localparam int OFS = ofs_bits(WB_DATA_WIDTH);

    wb_state_e                state_q, state_d;
    logic                     ack_d, err_d;
    logic                     mem_we, dat_r_ld;
    logic                     addr_bad;
    logic [MEM_ADDR_BITS-1:0] word_addr;
    logic [WB_DATA_WIDTH-1:0] mem_rdata;
    logic                     unused_adr;

    // Byte-offset bits select nothing: the bus is word-wide and sel picks lanes.
    assign word_addr  = adr[MEM_ADDR_BITS+OFS-1:OFS];
    assign unused_adr = ^adr;

`ifdef WB_SRAM_ADDR_CHECK_EN
    assign addr_bad = |(adr >> (MEM_ADDR_BITS + OFS));
`else
    assign addr_bad = 1'b0;
`endif

    // Next-state and per-cycle strobes; ACK never samples stb.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        dat_r_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cyc && stb) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else if (we) begin
                        mem_we  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                dat_r_ld = 1'b1;
                ack_d    = 1'b1;
                state_d  = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ack     <= 1'b0;
            err     <= 1'b0;
            dat_r   <= '0;
        end else begin
            state_q <= state_d;
            ack     <= ack_d;
            err     <= err_d;
            if (dat_r_ld) begin
                dat_r <= mem_rdata;
            end
        end
    end

    // Writes are blocked while reset is held so a parked master cannot
    // commit anything before the bridge is live.
    byte_en_sram_mem #(
        .ADDR_BITS (MEM_ADDR_BITS),
        .NB        (NB)
    ) u_mem (
        .clk     (clk),
        .addr    (word_addr),
        .we      (mem_we & rstn),
        .byte_en (sel),
        .wdata   (dat_w),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_wb_byte_en_sram_ctrl.sv
// Directed self-checking bench for wb_byte_en_sram_ctrl (32-bit data, 10 address bits).
module tb_wb_byte_en_sram_ctrl;

    logic        clk;
    logic        rstn;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic        ack;
    logic        err;

    int          tests;
    int          fails;
    logic [31:0] exp_dat_r;

    wb_byte_en_sram_ctrl #(
        .MEM_ADDR_BITS    (10),
        .WB_ADDRESS_WIDTH (32),
        .WB_DATA_WIDTH    (32)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .adr   (adr),
        .dat_w (dat_w),
        .dat_r (dat_r),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .sel   (sel),
        .ack   (ack),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Single write; exp_err selects ack or err response.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_err);
        adr = a; dat_w = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("wr_ack", {31'd0, ack}, {31'd0, !exp_err});
        chk("wr_err", {31'd0, err}, {31'd0, exp_err});
        chk("wr_dat_r_hold", dat_r, exp_dat_r);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("wr_ack_clr", {30'd0, ack, err}, 32'd0);
    endtask

    // Single read: no ack in RD, ack plus data one cycle later.
    task automatic wb_read(input logic [31:0] a, input logic [31:0] expd);
        adr = a; sel = 4'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rd_no_early_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("rd_ack", {31'd0, ack}, 32'd1);
        chk("rd_data", dat_r, expd);
        exp_dat_r = expd;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("rd_ack_clr", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        int acks;
        tests = 0; fails = 0; exp_dat_r = 32'd0;
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat_w = 32'd0; sel = 4'h0;

        // Reset state
        #12;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat_r", dat_r, 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_no_ack", {31'd0, ack}, 32'd0);
        end

        // Full-word write and read-back, byte offset ignored on read
        wb_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        wb_read(32'h10, 32'hDEADBEEF);
        wb_read(32'h13, 32'hDEADBEEF);

        // Byte enables
        wb_write(32'h20, 32'h11223344, 4'hF, 1'b0);
        wb_write(32'h20, 32'hAABBCCDD, 4'h5, 1'b0);
        wb_read(32'h20, 32'h11BB33DD);
        wb_write(32'h20, 32'hFFFFFFFF, 4'h0, 1'b0);
        wb_read(32'h20, 32'h11BB33DD);

        // Held strobe on reads: ack on cycles 2, 5, 8 after first accept only
        adr = 32'h10; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("held_ack", {31'd0, ack}, {31'd0, (k % 3) == 2});
            chk("held_err", {31'd0, err}, 32'd0);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held_ack_count", acks, 32'd3);
        @(posedge clk); #1;
        exp_dat_r = 32'hDEADBEEF;
        chk("held_dat_r", dat_r, 32'hDEADBEEF);
        @(posedge clk); #1;

`ifdef WB_SRAM_ADDR_CHECK_EN
        // Out-of-range write errors and leaves word 0 untouched
        wb_write(32'h0, 32'h12345678, 4'hF, 1'b0);
        wb_write(32'h1000, 32'h55AA55AA, 4'hF, 1'b1);
        wb_read(32'h0, 32'h12345678);
        // Out-of-range read errors after one cycle with dat_r unchanged
        adr = 32'h1000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("bad_rd_err", {31'd0, err}, 32'd1);
        chk("bad_rd_ack", {31'd0, ack}, 32'd0);
        chk("bad_rd_dat_r", dat_r, 32'h12345678);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("bad_rd_clr", {30'd0, ack, err}, 32'd0);
`else
        // Upper address bits alias onto the array; err never fires
        wb_write(32'h1000, 32'h55AA55AA, 4'hF, 1'b0);
        wb_read(32'h0, 32'h55AA55AA);
        chk("alias_err", {31'd0, err}, 32'd0);
`endif

        // Reset asserted while in RD
        adr = 32'h20; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("mid_rd_no_ack", {31'd0, ack}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_dat_r", dat_r, 32'd0);
        exp_dat_r = 32'd0;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {31'd0, ack}, 32'd0);
        end
        wb_read(32'h20, 32'h11BB33DD);
        wb_read(32'h10, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
